// File: rtl/dram_multicycle.sv
// dram_multicycle: single-port word memory with a fixed multi-cycle access latency.
//
// A request is accepted when req_valid & req_ready. The operation (byte-masked
// write or registered read) takes effect LATENCY-1 edges after acceptance, and
// resp_valid pulses for one cycle right after that. Misaligned or out-of-range
// requests complete with err=1 and data_out=0 and leave memory untouched.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous, active-low reset (does not clear memory)
//   req_valid  - request present
//   req_ready  - high only while idle
//   wr         - 1 = write, 0 = read
//   addr       - byte address
//   data_in    - write data
//   byte_en    - per-byte write strobe (ignored on reads)
//   resp_valid - one-cycle completion pulse
//   data_out   - read data, held until the next response
//   err        - request faulted, held until the next response
//   createdump - simulation dump trigger; it has no effect on the hardware
module dram_multicycle #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 8192,
  parameter int LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   data_out,
  output logic                err,
  input  logic                createdump
);

  localparam int NB     = DATA_W / 8;
  localparam int OFS    = $clog2(NB);
  localparam int IDXF_W = ADDR_W - OFS;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;

  // Request capture registers
  logic               r_wr;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic [NB-1:0]      r_be;

  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               r_resp_valid;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_err;

  logic               w_accept;
  logic               w_op;
  logic               w_op_wr;
  logic [ADDR_W-1:0]  w_op_addr;
  logic [DATA_W-1:0]  w_op_data;
  logic [NB-1:0]      w_op_be;
  logic [IDXF_W-1:0]  w_op_idx_full;
  logic [IDX_W-1:0]   w_mem_idx;
  logic               w_op_err;

  // The dump trigger is a simulation hook only; nothing in hardware reacts to it.
  logic               w_unused_dump;
  assign w_unused_dump = createdump;

  assign req_ready  = (r_state == S_IDLE);
  assign w_accept   = req_valid & req_ready;
  assign resp_valid = r_resp_valid;
  assign data_out   = r_data_out;
  assign err        = r_err;

  // With LATENCY=1 the operation happens on the acceptance edge itself, so it
  // must use the live request inputs; otherwise it uses the captured copy.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign w_op      = w_accept;
      assign w_op_wr   = wr;
      assign w_op_addr = addr;
      assign w_op_data = data_in;
      assign w_op_be   = byte_en;
      logic w_unused_cap;
      assign w_unused_cap = r_wr ^ (^r_addr) ^ (^r_data) ^ (^r_be);
    end else begin : g_latn
      assign w_op      = (r_state == S_WAIT) && (r_cnt == CNT_W'(1));
      assign w_op_wr   = r_wr;
      assign w_op_addr = r_addr;
      assign w_op_data = r_data;
      assign w_op_be   = r_be;
    end
  endgenerate

  assign w_op_idx_full = w_op_addr[ADDR_W-1:OFS];
  assign w_mem_idx     = w_op_idx_full[IDX_W-1:0];
  assign w_op_err      = (w_op_addr[OFS-1:0] != '0) || (32'(w_op_idx_full) >= DEPTH);

  // Next-state logic: the counter is loaded with LATENCY-1 on acceptance and
  // counts down once per WAIT cycle; the operation fires when it reads 1.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (LATENCY > 1)) begin
          w_state_next = S_WAIT;
          w_cnt_next   = CNT_W'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wr   <= wr;
      r_addr <= addr;
      r_data <= data_in;
      r_be   <= byte_en;
    end
  end

  // Memory array: no reset, so contents survive rst. Gating on rst drops any
  // in-flight write whose operation edge coincides with reset.
  always_ff @(posedge clk) begin
    if (rst && w_op && w_op_wr && !w_op_err) begin
      for (int b = 0; b < NB; b++) begin
        if (w_op_be[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= w_op_data[8*b +: 8];
        end
      end
    end
  end

  // Response registers double as the registered read port of the array.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_resp_valid <= 1'b0;
      r_data_out   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= w_op;
      if (w_op) begin
        r_err <= w_op_err;
        if (!w_op_err && !w_op_wr) begin
          r_data_out <= r_mem[w_mem_idx];
        end else begin
          r_data_out <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_multicycle.sv
// Bench for dram_multicycle: one LATENCY=4 instance exercised with directed and
// random transactions against a word-array reference model, plus a LATENCY=1
// instance checked for back-to-back single-cycle operation.
module tb_dram_multicycle;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int DEP = 8192;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;

  logic          req_valid, req_ready, wr, resp_valid, err, createdump;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in, data_out;
  logic [3:0]    byte_en;

  logic          req_valid1, req_ready1, wr1, resp_valid1, err1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] data_in1, data_out1;
  logic [3:0]    byte_en1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [0:DEP-1];
  logic [31:0] last_data;
  logic        last_err;

  always #5 clk = ~clk;

  dram_multicycle #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .wr(wr), .addr(addr), .data_in(data_in), .byte_en(byte_en),
    .resp_valid(resp_valid), .data_out(data_out), .err(err),
    .createdump(createdump)
  );

  dram_multicycle #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .wr(wr1), .addr(addr1), .data_in(data_in1), .byte_en(byte_en1),
    .resp_valid(resp_valid1), .data_out(data_out1), .err(err1),
    .createdump(createdump)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a plain word array updated by the addressing/byte rules.
  function automatic void model_op(input logic w, input logic [15:0] a, input logic [31:0] d,
                                   input logic [3:0] be, output logic e, output logic [31:0] q);
    int idx;
    idx = int'(a) / 4;
    e = ((int'(a) % 4) != 0) || (idx >= DEP);
    q = 32'd0;
    if (!e) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        q = mdl[idx];
      end
    end
  endfunction

  // Called at a falling edge of an idle cycle; returns at the falling edge of
  // the response cycle. Junk requests are presented during the wait cycles.
  task automatic do_op(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] be, input string tag);
    logic        e;
    logic [31:0] q;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; wr = w; addr = a; data_in = d; byte_en = be;
    model_op(w, a, d, be, e, q);
    @(posedge clk);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) begin
        chk({tag, "_wait_rv"},    32'(resp_valid), 32'd0);
        chk({tag, "_wait_ready"}, 32'(req_ready),  32'd0);
        chk({tag, "_hold_data"},  data_out,        last_data);
        chk({tag, "_hold_err"},   32'(err),        32'(last_err));
        req_valid = 1'b1;
        wr        = 1'($urandom);
        addr      = 16'($urandom);
        data_in   = $urandom;
        byte_en   = 4'($urandom);
      end else begin
        chk({tag, "_rv"},   32'(resp_valid), 32'd1);
        chk({tag, "_data"}, data_out,        q);
        chk({tag, "_err"},  32'(err),        32'(e));
        req_valid = 1'b0;
      end
    end
    last_data = q;
    last_err  = e;
    $display("txn %s wr=%0d addr=%h din=%h be=%b -> err=%0d dout=%h",
             tag, w, a, d, be, e, q);
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] ra;
    int          r;

    foreach (mdl[i]) mdl[i] = 32'd0;
    last_data = 32'd0;
    last_err  = 1'b0;
    req_valid = 1'b0; wr = 1'b0; addr = '0; data_in = '0; byte_en = '0;
    req_valid1 = 1'b0; wr1 = 1'b0; addr1 = '0; data_in1 = '0; byte_en1 = '0;
    createdump = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rv",   32'(resp_valid), 32'd0);
    chk("rst_data", data_out,        32'd0);
    chk("rst_err",  32'(err),        32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rv1",   32'(resp_valid1), 32'd0);

    // Full-word write and read back
    do_op(1'b1, 16'h0010, 32'hDEADBEEF, 4'b1111, "w_full");
    do_op(1'b0, 16'h0010, 32'h0,        4'b0000, "r_full");
    chk("r_full_lit", data_out, 32'hDEADBEEF);

    // Single-byte masked write
    do_op(1'b1, 16'h0010, 32'h0000AA00, 4'b0010, "w_byte");
    do_op(1'b0, 16'h0010, 32'h0,        4'b1111, "r_byte");
    chk("r_byte_lit", data_out, 32'hDEADAAEF);

    // Faulting requests, then confirm word 4 untouched
    do_op(1'b1, 16'h0012, 32'h11223344, 4'b1111, "w_misalign");
    chk("w_misalign_err_lit", 32'(err), 32'd1);
    do_op(1'b0, 16'h8000, 32'h0,        4'b1111, "r_range");
    chk("r_range_err_lit", 32'(err), 32'd1);
    do_op(1'b0, 16'h0010, 32'h0,        4'b0000, "r_after_err");
    do_op(1'b1, 16'h0004, 32'h12345678, 4'b0000, "w_noop");

    // Back-to-back reads with req_valid held high
    do_op(1'b1, 16'h0000, 32'hA5A5_0F0F, 4'b1111, "w_w0");
    do_op(1'b1, 16'h0004, 32'h5A5A_F0F0, 4'b1111, "w_w1");
    do_op(1'b0, 16'h0000, 32'h0,         4'b0000, "b2b_r0");
    do_op(1'b0, 16'h0004, 32'h0,         4'b0000, "b2b_r1");

    // Reset during an in-flight write aborts it
    req_valid = 1'b1; wr = 1'b1; addr = 16'h0020; data_in = 32'h12345678; byte_en = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("abort_rv",   32'(resp_valid), 32'd0);
      chk("abort_data", data_out,        32'd0);
      chk("abort_err",  32'(err),        32'd0);
      @(negedge clk);
    end
    $display("txn abort_write addr=0020 din=12345678 -> no response");
    last_data = 32'd0;
    last_err  = 1'b0;
    do_op(1'b0, 16'h0020, 32'h0, 4'b0000, "r_aborted");
    chk("r_aborted_lit", data_out, 32'd0);

    // LATENCY=1 instance: write then read back-to-back
    v = $urandom;
    chk("l1_ready0", 32'(req_ready1), 32'd1);
    req_valid1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0004; data_in1 = v; byte_en1 = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    chk("l1_w_rv",    32'(resp_valid1), 32'd1);
    chk("l1_w_err",   32'(err1),        32'd0);
    chk("l1_w_data",  data_out1,        32'd0);
    chk("l1_ready1",  32'(req_ready1),  32'd1);
    $display("txn l1_write addr=0004 din=%h", v);
    wr1 = 1'b0; data_in1 = $urandom;
    @(posedge clk);
    @(negedge clk);
    chk("l1_r_rv",    32'(resp_valid1), 32'd1);
    chk("l1_r_data",  data_out1,        v);
    chk("l1_r_err",   32'(err1),        32'd0);
    chk("l1_ready2",  32'(req_ready1),  32'd1);
    $display("txn l1_read addr=0004 dout=%h", v);
    req_valid1 = 1'b0;
    @(negedge clk);
    chk("l1_idle_rv",   32'(resp_valid1), 32'd0);
    chk("l1_hold_data", data_out1,        v);

    // Random traffic against the model
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      ra = 16'($urandom_range(0, 31) * 4);
      else if (r < 9) ra = 16'($urandom_range(0, 127));
      else            ra = 16'h8000 | 16'($urandom);
      do_op(1'($urandom), ra, $urandom, 4'($urandom), $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_multicycle.md
DRAM_MULTICYCLE -- requirements
Module: dram_multicycle

Interface
REQ-001 SHALL have parameter DATA_W, 32, data word width in bits (multiple of 8, power of 2, >=16).
REQ-002 SHALL have parameter ADDR_W, 16, byte address width.
REQ-003 SHALL have parameter DEPTH, 8192, number of DATA_W words stored.
REQ-004 SHALL have parameter LATENCY, 4, cycles from request acceptance to response (>=1).
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port req_valid  in  1  request present.
REQ-008 SHALL have port req_ready  out  1  block can accept a request this cycle.
REQ-009 SHALL have port wr  in  1  1 = write, 0 = read; sampled on acceptance.
REQ-010 SHALL have port addr  in  ADDR_W  byte address; sampled on acceptance.
REQ-011 SHALL have port data_in  in  DATA_W  write data; sampled on acceptance.
REQ-012 SHALL have port byte_en  in  DATA_W/8  per-byte write strobe; sampled on acceptance.
REQ-013 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-014 SHALL have port data_out  out  DATA_W  read data, valid with resp_valid.
REQ-015 SHALL have port err  out  1  request faulted, valid with resp_valid.
REQ-016 SHALL have port createdump  in  1  simulation-only dump trigger.

Function
REQ-017 SHALL define OFS = log2(DATA_W/8) and word index = addr[ADDR_W-1:OFS].
REQ-018 SHALL accept a request in cycle T when req_valid & req_ready; capture wr, addr, data_in, byte_en into registers.
REQ-019 SHALL implement states IDLE and WAIT; req_ready = 1 only in IDLE; IDLE->WAIT on acceptance when LATENCY>1; WAIT->IDLE when down-counter (loaded LATENCY-1, decremented each WAIT cycle) reaches 1.
REQ-020 SHALL perform the operation at the clock edge ending cycle T+LATENCY-1 and assert resp_valid for exactly cycle T+LATENCY; with LATENCY=1 the operation occurs at the acceptance edge and state stays IDLE.
REQ-021 SHALL be back in IDLE during the response cycle, so a new request may be accepted in the same cycle resp_valid is high; sustained throughput one request per LATENCY cycles.
REQ-022 SHALL flag error when addr[OFS-1:0] != 0 or word index >= DEPTH; errored requests take full LATENCY, give resp_valid with err=1, data_out=0, and never modify memory.
REQ-023 SHALL, on non-error write, update only bytes whose byte_en bit is 1; byte_en=0 is a legal no-op write; write responses drive data_out=0, err=0.
REQ-024 SHALL, on non-error read, register mem[index] into data_out at the operation edge; byte_en ignored on reads.
REQ-025 SHALL hold data_out and err at last response values until the next response; they are don't-care when resp_valid=0 but must be stable.
REQ-026 SHALL ignore req_valid and all request inputs while in WAIT (no queueing).
REQ-027 SHALL initialise memory to all zero at simulation start; reset does not clear memory.
REQ-028 SHALL, when createdump=1 at a rising edge and not in reset, write file "dumpfile" with words 0 through the highest word index ever written, one per line as index and hex data.

Reset
REQ-029 SHALL, while rst=0 at a rising edge, set state IDLE, counter 0, resp_valid 0, data_out 0, err 0; req_ready reads 1 from the cycle after reset release.
REQ-030 SHALL abort any in-flight request on reset: write not committed, no resp_valid produced.

Verification (DATA_W=32, ADDR_W=16, DEPTH=8192, LATENCY=4)
REQ-031 Write 0xDEADBEEF to 0x0010, byte_en=1111 accepted cycle 0 -> req_ready 0 cycles 1-3, resp_valid cycle 4 only, err 0; then read 0x0010 -> data_out 0xDEADBEEF with resp_valid.
REQ-032 Write 0x0000AA00 to 0x0010 byte_en=0010 -> subsequent read returns 0xDEADAAEF.
REQ-033 Write to 0x0012 (misaligned) and read from 0x8000 (index 8192) -> each resp err=1, data_out=0; mem word 4 unchanged.
REQ-034 req_valid held high continuously with reads to 0x0000 and 0x0004 -> accepts in cycles 0 and 4, resp_valid in cycles 4 and 8, correct data each.
REQ-035 Write 0x12345678 to 0x0020 accepted cycle 0, rst=0 in cycle 2 -> no resp_valid, outputs zero, later read of 0x0020 returns 0x00000000.
REQ-036 LATENCY=1 build: write then read 0x0004 back-to-back -> resp_valid high cycles 1 and 2, req_ready constantly 1, read data correct.
